// File: rtl/tt_um_mac_reader.sv
// tt_um_mac_reader: 8-entry x 8-bit FIFO that captures result bytes from an
// upstream MAC producer so a host can read them out one at a time.
// Push and pop are rising-edge events on uio_in[0] / uio_in[1].
// The optional running checksum is enabled by defining MAC_READER_CHECKSUM_EN.
module tt_um_mac_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] mem [8];
    logic [2:0] rd_ptr;
    logic [2:0] wr_ptr;
    logic [3:0] count;
    logic       push_prev;
    logic       pop_prev;
    logic       overflow;
    logic       underflow;

    logic       push_ev;
    logic       pop_ev;
    logic       clear;
    logic       empty;
    logic       full;
    logic       do_push;
    logic       do_pop;
    logic [7:0] head;
    logic       unused_bits;

    assign push_ev = ena & uio_in[0] & ~push_prev;
    assign pop_ev  = ena & uio_in[1] & ~pop_prev;
    assign clear   = ena & uio_in[3];
    assign empty   = (count == 4'd0);
    assign full    = (count == 4'd8);

    // A pop only succeeds with data present; a push into a full FIFO only
    // succeeds when a pop frees the slot on the same edge.
    assign do_pop  = pop_ev & ~empty;
    assign do_push = push_ev & (~full | pop_ev);

    // Previous strobe levels for edge detection; frozen while disabled so a
    // strobe toggled during ena=0 never registers as an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_prev <= 1'b0;
            pop_prev  <= 1'b0;
        end else if (ena) begin
            push_prev <= uio_in[0];
            pop_prev  <= uio_in[1];
        end
    end

    // Pointers, occupancy and sticky error flags; clear overrides any event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 3'd0;
            wr_ptr    <= 3'd0;
            count     <= 4'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= 3'd0;
            wr_ptr    <= 3'd0;
            count     <= 4'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (push_ev && full && !pop_ev) begin
                overflow <= 1'b1;
            end
            if (pop_ev && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are not reset since count alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= ui_in;
        end
    end

    assign head = empty ? 8'h00 : mem[rd_ptr];

`ifdef MAC_READER_CHECKSUM_EN
    logic [7:0] checksum;

    // Mod-256 sum of every byte actually written into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= 8'h00;
        end else if (clear) begin
            checksum <= 8'h00;
        end else if (do_push) begin
            checksum <= checksum + ui_in;
        end
    end

    assign uo_out      = uio_in[2] ? checksum : head;
    assign unused_bits = ^uio_in[7:4];
`else
    assign uo_out      = head;
    assign unused_bits = ^{uio_in[7:4], uio_in[2]};
`endif

    assign uio_out = {underflow, overflow, full, empty, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
